ddr_instr_packer: RTL
=====================

DDR_INSTR_PACKER -- requirements
Module: ddr_instr_packer

Interface
REQ-001 Parameter: TIMEOUT, default 16, meaning idle cycles a partial word may wait before auto-pad (range 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  DDR command offered.
REQ-005 cmd_ready  output  1  command accepted this cycle when cmd_valid&cmd_ready.
REQ-006 cmd_op  input  3  DDR opcode (WRITE, READ, PRE, ACT, ZQ, REF, NOP per encoding.vh).
REQ-007 cmd_bar  input  4  bank-address register index.
REQ-008 cmd_addr  input  4  CAR index (WRITE/READ) or RAR index (ACT).
REQ-009 cmd_flags  input  6  {pre_all, rank, bl4, ap, inc_addr, inc_bar}.
REQ-010 flush  input  1  pad current partial word with NOPs and emit it.
REQ-011 out_valid  output  1  out_instr holds a packed DDR instruction.
REQ-012 out_ready  input  1  consumer (instruction memory writer) takes out_instr.
REQ-013 out_instr  output  INSTR_WIDTH  packed instruction, decodable by the decode stage.
REQ-014 busy  output  1  high while partial word held or out_valid.
REQ-015 stat_words  output  32  count of instructions emitted.
REQ-016 stat_pads  output  32  count of NOP slots inserted by flush/timeout.

Function
REQ-017 Slot encoding: each command encodes to 16 bits using encoding.vh positions DDR_CODE_OFFSET, DEC_BAR, DEC_CAR, DEC_RAR, DEC_INC_BAR, DEC_INC_CAR, DEC_INC_RAR, DEC_AP, DEC_BL4, DEC_RANK, DEC_PRE_ALL; only fields defined for that opcode are populated, all others 0.
REQ-018 Field selection: WRITE/READ carry bar, car, inc_bar, inc_car, ap, bl4, rank; PRE carries pre_all, inc_bar, bar, rank; ACT carries rar, inc_rar, bar, inc_bar, rank; ZQ/REF/NOP carry rank only.
REQ-019 Unlisted cmd_op values encode as NOP with rank; not counted in stat_pads.
REQ-020 Packing: k-th accepted command (k=0..3) of a word lands in out_instr[16*k +: 16]; bits above 63 zero except instr[DDR_OFFSET]=1.
REQ-021 Pad slot = NOP opcode, rank 0, all other bits 0.
REQ-022 State: fill count cnt (0..3), slot accumulator, one output register, idle counter.
REQ-023 out_free = ~out_valid | out_ready.
REQ-024 cmd_ready = (cnt<3) | out_free; never depends on cmd_valid.
REQ-025 Completion: accepting 4th command moves the word into output register; out_valid high next cycle; cnt returns 0.
REQ-026 Latency: 4th command accepted cycle N -> out_valid=1 at N+1 with all four slots.
REQ-027 Flush: when flush=1 and (cnt>0 or a command accepted same cycle), pad remaining slots, transfer when out_free; held pending (sticky) until transfer; flush with cnt=0 and no accept is ignored.
REQ-028 Flush with simultaneous accept: accepted command placed first, then padding.
REQ-029 Timeout: idle counter increments each cycle with 0<cnt and no accept; clears on accept or transfer; reaching TIMEOUT acts as flush.
REQ-030 Output holds stable while out_valid&~out_ready; cleared after handshake unless replaced same cycle.
REQ-031 stat_words +1 per out_valid&out_ready; stat_pads += padded slot count at transfer; both wrap at 2^32.

Reset
REQ-032 On rst: out_valid=0, out_instr=0, cnt=0, idle=0, pending flush cleared, stat_words=0, stat_pads=0, busy=0; partial word discarded mid-operation.
REQ-033 cmd_ready=1 in the cycle after rst deasserts.

Verification
REQ-034 Four back-to-back ACT(bar=1,rar=2), out_ready=1 -> out_valid one cycle after 4th accept, four identical ACT slots, stat_words=1.
REQ-035 WRITE(bar=3,car=5,ap=1) then flush -> slot0 WRITE fields, slots1-3 NOP, stat_pads=3.
REQ-036 One PRE(pre_all=1), no further input, TIMEOUT=16 -> out_valid asserts after 16 idle cycles, stat_pads=3.
REQ-037 out_ready=0 with one word held, 4 more commands -> 4th command stalls (cmd_ready=0) until out_ready=1; no data loss, order preserved.
REQ-038 rst asserted with cnt=2 and out_valid=1 -> next cycle out_valid=0, stats 0; next word starts at slot0.
REQ-039 flush same cycle as 4th accept -> single full word, stat_pads unchanged.

Source files
------------

// File: rtl/ddr_instr_packer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_instr_packer
// Purpose  : Packs a stream of DDR commands into wide instruction words of
//            four 16-bit slots each. A partial word is padded with NOP slots
//            and emitted on an explicit flush or after TIMEOUT idle cycles.
//            One output register decouples the packer from the consumer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   cmd_valid   command offered
//   cmd_ready   command accepted when cmd_valid & cmd_ready
//   cmd_op      DDR opcode
//   cmd_bar     bank-address register index
//   cmd_addr    CAR index (WRITE/READ) or RAR index (ACT)
//   cmd_flags   {pre_all, rank, bl4, ap, inc_addr, inc_bar}
//   flush       pad the current partial word with NOPs and emit it
//   out_valid   out_instr holds a packed instruction
//   out_ready   consumer takes out_instr
//   out_instr   packed instruction word
//   busy        partial word held or output valid
//   stat_words  number of instructions handed to the consumer
//   stat_pads   number of NOP pad slots inserted by flush/timeout
// ----------------------------------------------------------------------------
// Slot layout (16 bits):
//   [2:0]   opcode            [6:3]  bar
//   [10:7]  car (WR/RD) / rar (ACT)
//   [11]    inc_bar           [12]   inc_car (WR/RD) / inc_rar (ACT)
//   [13]    ap (WR/RD) / pre_all (PRE)
//   [14]    bl4               [15]   rank
// Fields that share a position are never defined for the same opcode, so the
// opcode alone tells the decoder how to interpret them.
// ============================================================================
module ddr_instr_packer #(
  parameter int TIMEOUT     = 16,
  parameter int INSTR_WIDTH = 72,
  parameter int DDR_OFFSET  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [3:0]             cmd_bar,
  input  logic [3:0]             cmd_addr,
  input  logic [5:0]             cmd_flags,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   busy,
  output logic [31:0]            stat_words,
  output logic [31:0]            stat_pads
);

  // Opcode encoding
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_READ  = 3'd2;
  localparam logic [2:0] OP_PRE   = 3'd3;
  localparam logic [2:0] OP_ACT   = 3'd4;
  localparam logic [2:0] OP_ZQ    = 3'd5;
  localparam logic [2:0] OP_REF   = 3'd6;

  // Slot field positions
  localparam int DDR_CODE_OFFSET = 0;
  localparam int DEC_BAR         = 3;
  localparam int DEC_CAR         = 7;
  localparam int DEC_RAR         = 7;
  localparam int DEC_INC_BAR     = 11;
  localparam int DEC_INC_CAR     = 12;
  localparam int DEC_INC_RAR     = 12;
  localparam int DEC_AP          = 13;
  localparam int DEC_PRE_ALL     = 13;
  localparam int DEC_BL4         = 14;
  localparam int DEC_RANK        = 15;

  // Last idle-count value before the timeout fires; the cycle spent at this
  // value is the TIMEOUT-th idle cycle and acts as a flush.
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]             r_cnt;
  logic [15:0]            r_slot [0:2];
  logic                   r_out_valid;
  logic [INSTR_WIDTH-1:0] r_out_instr;
  logic [7:0]             r_idle;
  logic                   r_flush_pend;
  logic [31:0]            r_stat_words;
  logic [31:0]            r_stat_pads;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic                   w_pre_all;
  logic                   w_rank;
  logic                   w_bl4;
  logic                   w_ap;
  logic                   w_inc_addr;
  logic                   w_inc_bar;
  logic [15:0]            w_enc;
  logic                   w_out_free;
  logic                   w_accept;
  logic                   w_complete;
  logic                   w_timeout;
  logic                   w_flush_any;
  logic                   w_transfer;
  logic [2:0]             w_fill;
  logic [2:0]             w_pads;
  logic [INSTR_WIDTH-1:0] w_word;

  assign {w_pre_all, w_rank, w_bl4, w_ap, w_inc_addr, w_inc_bar} = cmd_flags;

  // Encode the offered command into one slot; only opcode-relevant fields
  // are populated, everything else stays zero.
  always_comb begin
    w_enc = '0;
    w_enc[DEC_RANK] = w_rank;
    case (cmd_op)
      OP_WRITE, OP_READ: begin
        w_enc[DDR_CODE_OFFSET +: 3] = cmd_op;
        w_enc[DEC_BAR +: 4]         = cmd_bar;
        w_enc[DEC_CAR +: 4]         = cmd_addr;
        w_enc[DEC_INC_BAR]          = w_inc_bar;
        w_enc[DEC_INC_CAR]          = w_inc_addr;
        w_enc[DEC_AP]               = w_ap;
        w_enc[DEC_BL4]              = w_bl4;
      end
      OP_PRE: begin
        w_enc[DDR_CODE_OFFSET +: 3] = cmd_op;
        w_enc[DEC_BAR +: 4]         = cmd_bar;
        w_enc[DEC_INC_BAR]          = w_inc_bar;
        w_enc[DEC_PRE_ALL]          = w_pre_all;
      end
      OP_ACT: begin
        w_enc[DDR_CODE_OFFSET +: 3] = cmd_op;
        w_enc[DEC_BAR +: 4]         = cmd_bar;
        w_enc[DEC_RAR +: 4]         = cmd_addr;
        w_enc[DEC_INC_BAR]          = w_inc_bar;
        w_enc[DEC_INC_RAR]          = w_inc_addr;
      end
      OP_ZQ, OP_REF: begin
        w_enc[DDR_CODE_OFFSET +: 3] = cmd_op;
      end
      default: begin
        // NOP and unassigned opcodes both become a NOP that keeps its rank.
        w_enc[DDR_CODE_OFFSET +: 3] = OP_NOP;
      end
    endcase
  end

  assign w_out_free = ~r_out_valid | out_ready;
  // Only the slot that completes a word needs the output register, so the
  // first three slots are always accepted.
  assign cmd_ready  = (r_cnt != 2'd3) | w_out_free;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_complete = w_accept & (r_cnt == 2'd3);

  // Timeout only counts cycles where a partial word sits without progress.
  assign w_timeout  = (r_cnt != 2'd0) & ~w_accept & (r_idle == IDLE_LAST);

  // Any reason to close the current partial word: a remembered flush, an
  // explicit flush with something to emit, or the idle timeout.
  assign w_flush_any = r_flush_pend | w_timeout |
                       (flush & ((r_cnt != 2'd0) | w_accept));

  // A completing accept implies the output is free (cmd_ready guarantees it).
  assign w_transfer = w_complete | (w_flush_any & w_out_free);

  assign w_fill = {1'b0, r_cnt} + {2'b00, w_accept};
  assign w_pads = 3'd4 - w_fill;

  // Assemble the outgoing word: stored slots first, then the command being
  // accepted this cycle, zero (NOP, rank 0) slots after that.
  always_comb begin
    w_word             = '0;
    w_word[DDR_OFFSET] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3 && 2'(k) < r_cnt) begin
        w_word[16*k +: 16] = r_slot[k];
      end else if (w_accept && 2'(k) == r_cnt) begin
        w_word[16*k +: 16] = w_enc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept && !w_transfer) begin
      r_slot[r_cnt] <= w_enc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 2'd0;
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_idle       <= 8'd0;
      r_flush_pend <= 1'b0;
      r_stat_words <= 32'd0;
      r_stat_pads  <= 32'd0;
    end else begin
      // Output register: load a new word, or clear after the handshake.
      if (w_transfer) begin
        r_out_instr <= w_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_instr <= '0;
        r_out_valid <= 1'b0;
      end

      if (r_out_valid && out_ready) begin
        r_stat_words <= r_stat_words + 32'd1;
      end

      if (w_transfer) begin
        r_stat_pads <= r_stat_pads + {29'd0, w_pads};
      end

      // Fill count
      if (w_transfer) begin
        r_cnt <= 2'd0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 2'd1;
      end

      // A flush that cannot transfer yet is remembered until it does.
      if (w_transfer) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_any) begin
        r_flush_pend <= 1'b1;
      end

      // Idle counter saturates at its last value; once there the flush is
      // already latched, so further counting carries no information.
      if (w_accept || w_transfer) begin
        r_idle <= 8'd0;
      end else if (r_cnt != 2'd0 && r_idle != IDLE_LAST) begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign busy       = (r_cnt != 2'd0) | r_out_valid;
  assign stat_words = r_stat_words;
  assign stat_pads  = r_stat_pads;

endmodule
`default_nettype wire
